m2_ebi_chan_endpoint: RTL and testbench



---
 rtl/ebi_pkg.sv | 16 +
 rtl/m2_ebi_chan_endpoint_if.sv | 37 +++
 rtl/ebi_sync_fifo.sv | 55 +++++
 rtl/m2_ebi_chan_endpoint.sv | 98 +++++++++
 tb/tb_m2_ebi_chan_endpoint.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ebi_pkg.sv
// Shared EBI types and constants for the M2-side channel endpoints.
package ebi_pkg;

  localparam int unsigned EBI_PERF_CNT_W = 16;
  localparam int unsigned EBI_NUM_CHAN   = 4;

  // Entry width of each M1->M2 channel (flit channels first, then credit channels).
  localparam int unsigned M1_M2_CHANNEL_LENGTH_LIST [EBI_NUM_CHAN] = '{64, 64, 32, 16};

  typedef enum logic [1:0] {
    EBI_M2_TX_IDLE = 2'd0,
    EBI_M2_TX_SEND = 2'd1,
    EBI_M2_TX_GAP  = 2'd2
  } ebi_m2_tx_state_e;

endpackage

// File: rtl/m2_ebi_chan_endpoint_if.sv
// Channel-side bundle of the M2 endpoint: ingress, dequeue, egress and perf signals.
interface m2_ebi_chan_endpoint_if
  import ebi_pkg::*;
#(
  parameter int unsigned ENTRY_W = 64,
  parameter int unsigned LVL_W   = 3
);
  logic                      in_valid_i;
  logic [ENTRY_W-1:0]        in_entry_i;
  logic                      push_ready_o;
  logic                      deq_valid_o;
  logic [ENTRY_W-1:0]        deq_entry_o;
  logic                      deq_ready_i;
  logic [LVL_W-1:0]          level_o;
  logic                      enq_valid_i;
  logic [ENTRY_W-1:0]        enq_entry_i;
  logic                      enq_ready_o;
  logic                      out_valid_o;
  logic [ENTRY_W-1:0]        out_entry_o;
  logic                      recv_success_i;
  logic [EBI_PERF_CNT_W-1:0] bp_cnt_o;
  logic [EBI_PERF_CNT_W-1:0] stall_cnt_o;

  // Endpoint view.
  modport slave (
    input  in_valid_i, in_entry_i, deq_ready_i, enq_valid_i, enq_entry_i, recv_success_i,
    output push_ready_o, deq_valid_o, deq_entry_o, level_o, enq_ready_o, out_valid_o,
           out_entry_o, bp_cnt_o, stall_cnt_o
  );

  // Environment view (M1 side plus M2 link logic).
  modport master (
    output in_valid_i, in_entry_i, deq_ready_i, enq_valid_i, enq_entry_i, recv_success_i,
    input  push_ready_o, deq_valid_o, deq_entry_o, level_o, enq_ready_o, out_valid_o,
           out_entry_o, bp_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/ebi_sync_fifo.sv
// Ingress FIFO: unreset storage, wrapping pointers, occupancy and registered not-full.
module ebi_sync_fifo #(
  parameter int unsigned ENTRY_W = 64,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                         m2_clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [ENTRY_W-1:0]           push_entry_i,
  input  logic                         pop_i,
  output logic                         push_ready_o,
  output logic                         deq_valid_o,
  output logic [ENTRY_W-1:0]           deq_entry_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ready_q;
  logic               push_fire, pop_fire;

  // Full blocks pushes even when a pop lands in the same cycle.
  assign push_fire = push_i & ready_q;
  assign pop_fire  = pop_i & (level_q != '0);
  assign level_d   = level_q + LVL_W'(push_fire) - LVL_W'(pop_fire);

  // Pointer, level and not-full registers.
  always_ff @(posedge m2_clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push_fire) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_fire)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      ready_q <= (level_d != LVL_W'(DEPTH));
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge m2_clk_i) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign push_ready_o = ready_q;
  assign deq_valid_o  = (level_q != '0);
  assign deq_entry_o  = mem_q[rd_ptr_q];
  assign level_o      = level_q;

endmodule

// File: rtl/m2_ebi_chan_endpoint.sv
// M2-side EBI channel endpoint: ingress FIFO, gapped egress handshake, optional perf counters.
// Optional feature macro: EBI_M2_CHAN_PERF_EN (backpressure/stall counters).
module m2_ebi_chan_endpoint
  import ebi_pkg::*;
#(
  parameter int unsigned ENTRY_W = M1_M2_CHANNEL_LENGTH_LIST[0],
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic                    m2_clk_i,
  input  logic                    rst_ni,
  m2_ebi_chan_endpoint_if.slave   bus
);
  logic [LVL_W-1:0]   level;
  logic               push_ready;
  logic               deq_valid;
  logic [ENTRY_W-1:0] deq_entry;

  ebi_sync_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .m2_clk_i     (m2_clk_i),
    .rst_ni       (rst_ni),
    .push_i       (bus.in_valid_i),
    .push_entry_i (bus.in_entry_i),
    .pop_i        (bus.deq_ready_i),
    .push_ready_o (push_ready),
    .deq_valid_o  (deq_valid),
    .deq_entry_o  (deq_entry),
    .level_o      (level)
  );

  assign bus.push_ready_o = push_ready;
  assign bus.deq_valid_o  = deq_valid;
  assign bus.deq_entry_o  = deq_entry;
  assign bus.level_o      = level;

  ebi_m2_tx_state_e   tx_state_q;
  logic [ENTRY_W-1:0] out_entry_q;

  // Egress FSM: load, hold until accepted, then force one idle cycle for the M1 receiver.
  always_ff @(posedge m2_clk_i) begin
    if (!rst_ni) begin
      tx_state_q  <= EBI_M2_TX_IDLE;
      out_entry_q <= '0;
    end else begin
      case (tx_state_q)
        EBI_M2_TX_IDLE: begin
          if (bus.enq_valid_i) begin
            out_entry_q <= bus.enq_entry_i;
            tx_state_q  <= EBI_M2_TX_SEND;
          end
        end
        EBI_M2_TX_SEND: begin
          if (bus.recv_success_i) tx_state_q <= EBI_M2_TX_GAP;
        end
        EBI_M2_TX_GAP: begin
          if (bus.enq_valid_i) begin
            out_entry_q <= bus.enq_entry_i;
            tx_state_q  <= EBI_M2_TX_SEND;
          end else begin
            tx_state_q  <= EBI_M2_TX_IDLE;
          end
        end
        default: tx_state_q <= EBI_M2_TX_IDLE;
      endcase
    end
  end

  assign bus.out_valid_o = (tx_state_q == EBI_M2_TX_SEND);
  assign bus.enq_ready_o = (tx_state_q != EBI_M2_TX_SEND);
  assign bus.out_entry_o = out_entry_q;

`ifdef EBI_M2_CHAN_PERF_EN
  logic [EBI_PERF_CNT_W-1:0] bp_cnt_q, stall_cnt_q;

  // Saturating ingress-backpressure and egress-stall cycle counters.
  always_ff @(posedge m2_clk_i) begin
    if (!rst_ni) begin
      bp_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.in_valid_i && !push_ready && (bp_cnt_q != '1))
        bp_cnt_q <= bp_cnt_q + EBI_PERF_CNT_W'(1);
      if ((tx_state_q == EBI_M2_TX_SEND) && !bus.recv_success_i && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + EBI_PERF_CNT_W'(1);
    end
  end

  assign bus.bp_cnt_o    = bp_cnt_q;
  assign bus.stall_cnt_o = stall_cnt_q;
`else
  assign bus.bp_cnt_o    = '0;
  assign bus.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_m2_ebi_chan_endpoint.sv
// Directed bench for m2_ebi_chan_endpoint with a cycle model and FIFO/egress scoreboards.
module tb_m2_ebi_chan_endpoint;
  localparam int unsigned ENTRY_W = 64;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LVL_W   = 3;
  localparam int ST_IDLE = 0;
  localparam int ST_SEND = 1;
  localparam int ST_GAP  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  m2_ebi_chan_endpoint_if #(.ENTRY_W(ENTRY_W), .LVL_W(LVL_W)) bus ();

  m2_ebi_chan_endpoint #(.ENTRY_W(ENTRY_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .m2_clk_i (clk),
    .rst_ni   (rst_n),
    .bus      (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [ENTRY_W-1:0] fq[$];
  logic [ENTRY_W-1:0] eq[$];
  int                 m_lvl;
  logic               m_rdy;
  int                 m_st;
  logic [ENTRY_W-1:0] m_out;
  int                 m_bp;
  int                 m_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    fq.delete();
    eq.delete();
    m_lvl = 0; m_rdy = 1'b1; m_st = ST_IDLE; m_out = '0; m_bp = 0; m_stall = 0;
  endtask

  task automatic check_outputs();
    chk("level",      64'(bus.level_o),      64'(m_lvl));
    chk("push_ready", 64'(bus.push_ready_o), 64'(m_rdy));
    chk("deq_valid",  64'(bus.deq_valid_o),  64'(m_lvl != 0));
    chk("out_valid",  64'(bus.out_valid_o),  64'(m_st == ST_SEND));
    chk("enq_ready",  64'(bus.enq_ready_o),  64'(m_st != ST_SEND));
    chk("out_entry",  64'(bus.out_entry_o),  64'(m_out));
    chk("bp_cnt",     64'(bus.bp_cnt_o),     64'(m_bp));
    chk("stall_cnt",  64'(bus.stall_cnt_o),  64'(m_stall));
  endtask

  // One clock with current inputs: scoreboard transfers, advance model, compare.
  task automatic cycle();
    logic push, pop, ev, rs;
    logic [ENTRY_W-1:0] exp_e;
    push = bus.in_valid_i && m_rdy;
    pop  = bus.deq_ready_i && (m_lvl != 0);
    ev   = bus.enq_valid_i;
    rs   = bus.recv_success_i;
    if (pop) begin
      exp_e = fq.pop_front();
      chk("deq_entry", 64'(bus.deq_entry_o), 64'(exp_e));
    end
    if (m_st == ST_SEND && rs) begin
      exp_e = eq.pop_front();
      chk("egress_accept_entry", 64'(bus.out_entry_o), 64'(exp_e));
    end
`ifdef EBI_M2_CHAN_PERF_EN
    if (bus.in_valid_i && !m_rdy && m_bp != 32'hFFFF) m_bp++;
    if (m_st == ST_SEND && !rs && m_stall != 32'hFFFF) m_stall++;
`endif
    if (push) fq.push_back(bus.in_entry_i);
    case (m_st)
      ST_SEND: if (rs) m_st = ST_GAP;
      default: begin
        if (ev) begin
          m_out = bus.enq_entry_i;
          eq.push_back(bus.enq_entry_i);
          m_st = ST_SEND;
        end else begin
          m_st = ST_IDLE;
        end
      end
    endcase
    tick();
    m_lvl = m_lvl + int'(push) - int'(pop);
    m_rdy = (m_lvl != DEPTH);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_clear();
    chk("rst_level",     64'(bus.level_o),     64'd0);
    chk("rst_deq_valid", 64'(bus.deq_valid_o), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_out_entry", 64'(bus.out_entry_o), 64'd0);
    chk("rst_enq_ready", 64'(bus.enq_ready_o), 64'd1);
    chk("rst_push_ready",64'(bus.push_ready_o),64'd1);
    check_outputs();
  endtask

  initial begin
    bus.in_valid_i = 1'b0; bus.in_entry_i = '0; bus.deq_ready_i = 1'b0;
    bus.enq_valid_i = 1'b0; bus.enq_entry_i = '0; bus.recv_success_i = 1'b0;
    model_clear();
    tick();
    do_reset();

    // Fill to DEPTH, hold an extra entry, then drain in order.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid_i = 1'b1;
      bus.in_entry_i = 64'(8'hA1 + i);
      cycle();
    end
    chk("full_level", 64'(bus.level_o), 64'd4);
    chk("full_push_ready", 64'(bus.push_ready_o), 64'd0);
    bus.in_entry_i = 64'hA5;
    cycle();
    cycle();
    chk("held_a5_level", 64'(bus.level_o), 64'd4);
    bus.deq_ready_i = 1'b1;
    cycle();
    chk("after_first_pop_ready", 64'(bus.push_ready_o), 64'd1);
    chk("after_first_pop_level", 64'(bus.level_o), 64'd3);
    cycle();
    chk("a5_accepted_level", 64'(bus.level_o), 64'd3);
    bus.in_valid_i = 1'b0;
    repeat (3) cycle();
    chk("drained_level", 64'(bus.level_o), 64'd0);

    // Concurrent push and pop at level 2.
    bus.deq_ready_i = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_entry_i = 64'hB1; cycle();
    bus.in_entry_i = 64'hB2; cycle();
    bus.deq_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_entry_i = 64'(8'hB3 + i);
      cycle();
      chk("steady_level2", 64'(bus.level_o), 64'd2);
    end
    bus.in_valid_i = 1'b0;
    repeat (2) cycle();

    // Back-to-back egress with constant acceptance: 1,0,1,0.
    bus.deq_ready_i = 1'b0;
    bus.recv_success_i = 1'b1;
    bus.enq_valid_i = 1'b1; bus.enq_entry_i = 64'h55;
    cycle();
    chk("eg_v0", 64'(bus.out_valid_o), 64'd1);
    chk("eg_e0", 64'(bus.out_entry_o), 64'h55);
    chk("eg_rdy_send0", 64'(bus.enq_ready_o), 64'd0);
    bus.enq_entry_i = 64'h66;
    cycle();
    chk("eg_v1", 64'(bus.out_valid_o), 64'd0);
    cycle();
    chk("eg_v2", 64'(bus.out_valid_o), 64'd1);
    chk("eg_e2", 64'(bus.out_entry_o), 64'h66);
    chk("eg_rdy_send2", 64'(bus.enq_ready_o), 64'd0);
    bus.enq_valid_i = 1'b0;
    cycle();
    chk("eg_v3", 64'(bus.out_valid_o), 64'd0);

    // Egress stall: held for three cycles, accepted on the fourth.
    bus.recv_success_i = 1'b0;
    bus.enq_valid_i = 1'b1; bus.enq_entry_i = 64'h77;
    cycle();
    bus.enq_valid_i = 1'b0; bus.enq_entry_i = 64'h99;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_valid", 64'(bus.out_valid_o), 64'd1);
      chk("stall_entry", 64'(bus.out_entry_o), 64'h77);
    end
`ifdef EBI_M2_CHAN_PERF_EN
    chk("stall_cnt3", 64'(bus.stall_cnt_o), 64'd3);
`endif
    bus.recv_success_i = 1'b1;
    cycle();
    chk("stall_to_gap", 64'(bus.out_valid_o), 64'd0);
    chk("hold_after_xfer", 64'(bus.out_entry_o), 64'h77);

    // Reset with level 3 and egress in SEND.
    bus.recv_success_i = 1'b0;
    bus.in_valid_i = 1'b1; bus.in_entry_i = 64'hC1;
    bus.enq_valid_i = 1'b1; bus.enq_entry_i = 64'h88;
    cycle();
    bus.enq_valid_i = 1'b0;
    bus.in_entry_i = 64'hC2; cycle();
    bus.in_entry_i = 64'hC3; cycle();
    bus.in_valid_i = 1'b0;
    chk("pre_rst_level", 64'(bus.level_o), 64'd3);
    chk("pre_rst_send", 64'(bus.out_valid_o), 64'd1);
    do_reset();

`ifdef EBI_M2_CHAN_PERF_EN
    // Long backpressure run: counter saturates.
    bus.in_valid_i = 1'b1; bus.in_entry_i = 64'hD0;
    repeat (4) cycle();
    repeat (32'h10005) cycle();
    chk("bp_saturated", 64'(bus.bp_cnt_o), 64'hFFFF);
    bus.in_valid_i = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
